// File: rtl/mips_pkg.sv
// Shared MIPS decode constants for the multiply/divide group, used by the
// MD sequencer and the stage controllers.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1A;
  localparam logic [5:0] FN_DIVU    = 6'h1B;

  function automatic logic is_md_funct(input logic [5:0] funct);
    return (funct == FN_MFHI) || (funct == FN_MTHI) || (funct == FN_MFLO) ||
           (funct == FN_MTLO) || (funct == FN_MULT) || (funct == FN_MULTU) ||
           (funct == FN_DIV)  || (funct == FN_DIVU);
  endfunction

  // mult/multu/div/divu occupy encodings 0..3, so bit 2 clear marks them.
  function automatic logic is_md_arith(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

  function automatic logic is_md_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath: produces {hi, lo} for one MD op.
module md_arith
  import mips_pkg::*;
(
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] result
);

  logic [63:0]        prod_s;
  logic [63:0]        prod_u;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  always_comb begin
    prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
    prod_u = {32'b0, rs_val} * {32'b0, rt_val};
    quot_s = '0;
    rem_s  = '0;
    quot_u = '0;
    rem_u  = '0;
    // A zero divisor leaves the result don't-care; the sequencer never commits it.
    if (rt_val != 32'd0) begin
      if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
        quot_s = $signed(32'h8000_0000);
        rem_s  = '0;
      end else begin
        quot_s = $signed(rs_val) / $signed(rt_val);
        rem_s  = $signed(rs_val) % $signed(rt_val);
      end
      quot_u = rs_val / rt_val;
      rem_u  = rs_val % rt_val;
    end
    case (md_op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV:   result = {rem_s, quot_s};
      MD_DIVU:  result = {rem_u, quot_u};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_sequencer.sv
// E-stage multiply/divide sequencer: holds HI/LO, models fixed MD latency with a
// countdown and requests D-stage stalls for MD-dependent instructions.
module md_sequencer
  import mips_pkg::*;
#(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [63:0]   pend;
  logic          pend_wr;
  logic [63:0]   arith_res;
  logic          arith_go;

  md_arith u_arith (
    .md_op  (md_op),
    .rs_val (rs_val),
    .rt_val (rt_val),
    .result (arith_res)
  );

  assign arith_go = start && is_md_arith(md_op);
  assign busy     = (count != '0);
  // The start term covers the issue cycle, before busy has risen.
  assign stall_md = md_use_d && (busy || arith_go);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      count   <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (arith_go) begin
            pend    <= arith_res;
            pend_wr <= !(is_md_div(md_op) && rt_val == 32'd0);
            count   <= is_md_div(md_op) ? CW'(DIV_LAT) : CW'(MULT_LAT);
            state   <= S_RUN;
          end else if (start && md_op == MD_MTHI) begin
            hi <= rs_val;
          end else if (start && md_op == MD_MTLO) begin
            lo <= rs_val;
          end
        end
        S_RUN: begin
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= S_IDLE;
            if (pend_wr) begin
              {hi, lo} <= pend;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  start_while_busy: assert property (@(posedge clk) disable iff (!reset_n) !(start && busy));

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed and random MD ops checked against an
// arithmetic reference model through an expected-result queue.
module tb_md_sequencer;
  import mips_pkg::*;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic        clk      = 1'b0;
  logic        reset_n  = 1'b1;
  logic        start    = 1'b0;
  logic [2:0]  md_op    = 3'd0;
  logic [31:0] rs_val   = 32'd0;
  logic [31:0] rt_val   = 32'd0;
  logic        use_fix  = 1'b0;
  logic        use_rand = 1'b0;
  logic        use_mode = 1'b0;
  logic        md_use_d;
  logic        busy;
  logic        stall_md;
  logic [31:0] hi;
  logic [31:0] lo;

  int          cyc      = 0;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          win_lo   = 0;
  int          win_hi   = -1;
  logic [31:0] m_hi     = 32'd0;
  logic [31:0] m_lo     = 32'd0;

  logic [63:0] exp_q[$];
  int          cyc_q[$];
  int          lat_q[$];

  assign md_use_d = use_mode ? use_rand : use_fix;

  md_sequencer #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_d (md_use_d),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    use_rand = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor / scoreboard
  int          run_len   = 0;
  logic        prev_busy = 1'b0;
  logic [63:0] arch      = 64'd0;

  always @(negedge clk) begin
    logic exp_busy;
    logic exp_stall;
    logic fell;
    logic popped;
    exp_busy  = (cyc >= win_lo) && (cyc <= win_hi);
    exp_stall = md_use_d && (exp_busy || (start && md_op <= 3'd3));
    chk("busy", 64'(busy), 64'(exp_busy));
    chk("stall_md", 64'(stall_md), 64'(exp_stall));
    fell   = prev_busy && !busy;
    popped = 1'b0;
    if (!reset_n) begin
      arch    = 64'd0;
      run_len = 0;
      chk("hilo_in_reset", {hi, lo}, 64'd0);
    end else begin
      if (exp_q.size() > 0) begin
        if (lat_q[0] != 0 && fell) begin
          chk("commit_cycle", 64'(cyc), 64'(cyc_q[0]));
          chk("busy_width", 64'(run_len), 64'(lat_q[0]));
          chk("hilo_commit", {hi, lo}, exp_q[0]);
          popped = 1'b1;
        end else if (lat_q[0] == 0 && cyc == cyc_q[0]) begin
          chk("hilo_move", {hi, lo}, exp_q[0]);
          popped = 1'b1;
        end else if (cyc > cyc_q[0]) begin
          n_checks++;
          n_fail++;
          $display("FAIL commit_missing: no result by cycle %0d, expected 0x%0h", cyc, exp_q[0]);
          popped = 1'b1;
        end
        if (popped) begin
          arch = exp_q.pop_front();
          void'(cyc_q.pop_front());
          void'(lat_q.pop_front());
        end
      end
      if (!popped) chk("hilo_hold", {hi, lo}, arch);
      run_len = busy ? run_len + 1 : 0;
    end
    prev_busy = busy;
  end

  // driver tasks
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int e);
    int              lat;
    int              sa;
    int              sb;
    longint          p;
    longint unsigned ua;
    longint unsigned ub;
    logic [31:0]     nh;
    logic [31:0]     nl;
    logic            arith;
    while (cyc < win_hi + 1) begin
      @(posedge clk);
      #1;
    end
    e     = cyc + 1;
    nh    = m_hi;
    nl    = m_lo;
    arith = (op <= 3'd3);
    lat   = (op == 3'd2 || op == 3'd3) ? DIV_LAT : MULT_LAT;
    sa    = a;
    sb    = b;
    ua    = {32'd0, a};
    ub    = {32'd0, b};
    case (op)
      3'd0: begin
        p = longint'(sa) * longint'(sb);
        {nh, nl} = p;
      end
      3'd1: {nh, nl} = ua * ub;
      3'd2: if (b != 32'd0) begin
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          nl = 32'h8000_0000;
          nh = 32'd0;
        end else begin
          nl = sa / sb;
          nh = sa % sb;
        end
      end
      3'd3: if (b != 32'd0) begin
        nl = a / b;
        nh = a % b;
      end
      3'd4: nh = a;
      3'd5: nl = a;
      default: ;
    endcase
    start  = 1'b1;
    md_op  = op;
    rs_val = a;
    rt_val = b;
    if (op <= 3'd5) begin
      m_hi = nh;
      m_lo = nl;
      exp_q.push_back({nh, nl});
      cyc_q.push_back(arith ? e + lat : e);
      lat_q.push_back(arith ? lat : 0);
    end
    if (arith) begin
      win_lo = e;
      win_hi = e + lat - 1;
    end
    @(posedge clk);
    #1;
    start  = 1'b0;
    md_op  = 3'($urandom_range(0, 7));
    rs_val = $urandom;
    rt_val = $urandom;
  endtask

  task automatic mid_reset();
    reset_n = 1'b0;
    exp_q.delete();
    cyc_q.delete();
    lat_q.delete();
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    win_lo = 0;
    win_hi = -1;
    #1;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hilo", {hi, lo}, 64'd0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset_n = 1'b1;
  endtask

  function automatic logic [31:0] pick(input bit allow_zero);
    int v;
    case ($urandom_range(0, 4))
      0: return $urandom;
      1: begin
        v = int'($urandom_range(0, 40));
        return 32'(v - 20);
      end
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return allow_zero ? 32'd0 : 32'd1;
    endcase
  endfunction

  initial begin
    int          e;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_busy", 64'(busy), 64'd0);
    chk("init_stall", 64'(stall_md), 64'd0);
    chk("init_hilo", {hi, lo}, 64'd0);
    reset_n = 1'b1;

    use_fix = 1'b1;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, e);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, e);
    issue(3'd2, 32'hFFFF_FFF9, 32'd2, e);
    issue(3'd4, 32'h11, 32'd0, e);
    issue(3'd5, 32'h22, 32'd0, e);
    issue(3'd3, 32'd100, 32'd0, e);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, e);
    issue(3'd6, 32'h55, 32'd1, e);

    issue(3'd2, 32'd1000, 32'd7, e);
    while (cyc < e + 7) begin
      @(posedge clk);
      #1;
    end
    mid_reset();
    issue(3'd0, 32'd12345, 32'hFFFF_FFFD, e);

    use_mode = 1'b1;
    repeat (60) begin
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
      end
      op = 3'($urandom_range(0, 7));
      a  = pick(1'b1);
      b  = pick(1'b1);
      issue(op, a, b, e);
    end

    while (cyc < win_hi + 3) begin
      @(posedge clk);
      #1;
    end
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
